// File: rtl/uart_rx_oversample_pkg.sv
// Shared UART definitions: receiver state encoding, default line parameters and
// small elaboration-time helpers used by the receiver and the tick generator.
package uart_rx_oversample_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEF_BAUD      = 9600;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_e;

    // Per-frame completion strobes, registered together so they stay aligned.
    typedef struct packed {
        logic valid;
        logic frame_err;
        logic parity_err;
    } rx_strobe_t;

    function automatic int unsigned tick_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_oversample_baud_tick_gen.sv
// Free-running divider producing a one-clock TICK every CLK_FREQ/(BAUD*OVERSAMPLE)
// clocks; shared by the RX path and (with OVERSAMPLE=1) the TX path.
module uart_rx_oversample_baud_tick_gen
    import uart_rx_oversample_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int unsigned DIV   = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CNT_W = cnt_width(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
        end
    end

    // TICK is registered but still aligned with the cycle where the counter sits at DIV-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_W'(DIV - 1));
        end
    end

    assign TICK = tick_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver: 2-FF synchroniser, oversampled centre-sampling FSM, and registered
// data/strobe outputs for the byte consumer.
module uart_rx_oversample
    import uart_rx_oversample_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 BUSY
);

    localparam int unsigned SCNT_W   = cnt_width(OVERSAMPLE);
    localparam int unsigned IDX_W    = cnt_width(DATA_BITS);
    localparam int unsigned HALF_CNT = OVERSAMPLE / 2 - 1;
    localparam int unsigned LAST_CNT = OVERSAMPLE - 1;

    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    rx_strobe_t           strobe_q, strobe_d;
    logic                 busy_q, busy_d;
    logic                 half_end_c;
    logic                 bit_end_c;
    logic                 par_mismatch_c;

    uart_rx_oversample_baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    // Synchroniser resets to the idle line level so reset never looks like a start edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign half_end_c     = tick && (scnt_q == SCNT_W'(HALF_CNT));
    assign bit_end_c      = tick && (scnt_q == SCNT_W'(LAST_CNT));
    assign par_mismatch_c = PARITY_EN && (par_bit_q != (^shift_q ^ PARITY_ODD));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (half_end_c) begin
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end_c && (idx_q == IDX_W'(DATA_BITS - 1))) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    state_d = rx_s_q ? ST_IDLE : ST_BRK_WAIT;
                end
            end
            ST_BRK_WAIT: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next-values; scnt keeps the tick phase, so sampling drifts by at most one tick.
    always_comb begin
        scnt_d    = scnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        strobe_d  = '0;
        busy_d    = (state_d != ST_IDLE);

        if (state_d != state_q) begin
            scnt_d = '0;
        end else if (bit_end_c) begin
            scnt_d = '0;
        end else if (tick && (state_q != ST_IDLE) && (state_q != ST_BRK_WAIT)) begin
            scnt_d = scnt_q + SCNT_W'(1);
        end

        case (state_q)
            ST_START: begin
                if (half_end_c && !rx_s_q) begin
                    idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    par_bit_d = rx_s_q;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    if (rx_s_q) begin
                        data_d              = shift_q;
                        strobe_d.valid      = 1'b1;
                        strobe_d.parity_err = par_mismatch_c;
                    end else begin
                        strobe_d.frame_err  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scnt_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            data_q    <= '0;
            strobe_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            scnt_q    <= scnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
        end
    end

    assign DATA       = data_q;
    assign VALID      = strobe_q.valid;
    assign FRAME_ERR  = strobe_q.frame_err;
    assign PARITY_ERR = strobe_q.parity_err;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: one 8N1 instance and one 8E1 instance, directed frames
// plus random frames, scored against a frame-level expectation queue.
module tb_uart_rx_oversample;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int unsigned OS       = 16;
    localparam int unsigned BIT_CLK  = CLK_FREQ / BAUD;

    logic       clk;
    logic       rst;
    logic       rx_n, rx_p;
    logic [7:0] data_n, data_p;
    logic       valid_n, ferr_n, perr_n, busy_n;
    logic       valid_p, ferr_p, perr_p, busy_p;

    uart_rx_oversample #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) dut_n (
        .CLK(clk), .RST(rst), .RX(rx_n), .DATA(data_n), .VALID(valid_n),
        .FRAME_ERR(ferr_n), .PARITY_ERR(perr_n), .BUSY(busy_n)
    );

    uart_rx_oversample #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) dut_p (
        .CLK(clk), .RST(rst), .RX(rx_p), .DATA(data_p), .VALID(valid_p),
        .FRAME_ERR(ferr_p), .PARITY_ERR(perr_p), .BUSY(busy_p)
    );

    typedef struct {
        logic       ferr;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t exp_n[$];
    exp_t exp_p[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_edge_cyc = 0;
    int n_valid_n = 0, n_ferr_n = 0, last_valid_cyc_n = 0;
    int n_valid_p = 0, last_perr_p = 0;
    logic prev_valid_n = 1'b0, prev_valid_p = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Frame-level outcome: a low stop bit is a framing error; otherwise the byte is
    // delivered and flagged when the sent parity bit disagrees with even parity.
    function automatic exp_t model(input logic [7:0] d, input bit stop_bit,
                                   input bit par_en, input bit par_bit);
        exp_t e;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        e.ferr = !stop_bit;
        e.data = d;
        e.perr = par_en && ((ones + int'(par_bit)) % 2 != 0);
        return e;
    endfunction

    task automatic drive_bit(input bit on_p, input bit v);
        if (on_p) rx_p = v; else rx_n = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input bit on_p, input logic [7:0] d,
                              input bit stop_bit, input bit par_bit);
        exp_t e;
        e = model(d, stop_bit, on_p, par_bit);
        if (on_p) exp_p.push_back(e); else exp_n.push_back(e);
        last_edge_cyc = cyc;
        drive_bit(on_p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(on_p, d[i]);
        if (on_p) drive_bit(on_p, par_bit);
        drive_bit(on_p, stop_bit);
    endtask

    always @(negedge clk) begin : mon_n
        exp_t e;
        if (valid_n) begin
            chk("n_valid_width", 32'(prev_valid_n), 32'd0);
            chk("n_valid_in_rst", 32'(rst), 32'd0);
            chk("n_valid_expected", 32'(exp_n.size() > 0), 32'd1);
            if (exp_n.size() > 0) begin
                e = exp_n.pop_front();
                chk("n_kind_valid", 32'(e.ferr), 32'd0);
                chk("n_data", 32'(data_n), 32'(e.data));
                chk("n_perr", 32'(perr_n), 32'(e.perr));
            end
            n_valid_n++;
            last_valid_cyc_n = cyc;
        end
        if (ferr_n) begin
            chk("n_ferr_excl", 32'(valid_n), 32'd0);
            chk("n_ferr_expected", 32'(exp_n.size() > 0), 32'd1);
            if (exp_n.size() > 0) begin
                e = exp_n.pop_front();
                chk("n_kind_ferr", 32'(e.ferr), 32'd1);
            end
            n_ferr_n++;
        end
        if (perr_n) chk("n_perr_coinc", 32'(valid_n), 32'd1);
        prev_valid_n = valid_n;
    end

    always @(negedge clk) begin : mon_p
        exp_t e;
        if (valid_p) begin
            chk("p_valid_width", 32'(prev_valid_p), 32'd0);
            chk("p_valid_expected", 32'(exp_p.size() > 0), 32'd1);
            if (exp_p.size() > 0) begin
                e = exp_p.pop_front();
                chk("p_kind_valid", 32'(e.ferr), 32'd0);
                chk("p_data", 32'(data_p), 32'(e.data));
                chk("p_perr", 32'(perr_p), 32'(e.perr));
            end
            n_valid_p++;
            last_perr_p = int'(perr_p);
        end
        if (ferr_p) begin
            chk("p_ferr_expected", 32'(exp_p.size() > 0), 32'd1);
            if (exp_p.size() > 0) begin
                e = exp_p.pop_front();
                chk("p_kind_ferr", 32'(e.ferr), 32'd1);
            end
        end
        if (perr_p) chk("p_perr_coinc", 32'(valid_p), 32'd1);
        prev_valid_p = valid_p;
    end

    initial begin
        int prev, prev_f, c1, c2, k, gap;
        logic [7:0] d;
        bit stop, pb;

        rst = 1'b1; rx_n = 1'b1; rx_p = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data_n), 32'd0);
        chk("rst_valid", 32'(valid_n), 32'd0);
        chk("rst_ferr", 32'(ferr_n), 32'd0);
        chk("rst_perr", 32'(perr_p), 32'd0);
        chk("rst_busy", 32'(busy_n), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(busy_n), 32'd0);

        // Single 8N1 frame and its latency from the start edge.
        prev = n_valid_n; prev_f = n_ferr_n;
        send_frame(1'b0, 8'h55, 1'b1, 1'b0);
        k = 0;
        while (n_valid_n == prev && k < 200) begin @(negedge clk); k++; end
        chk("t1_valid_count", 32'(n_valid_n - prev), 32'd1);
        chk("t1_latency_ok", 32'((last_valid_cyc_n - last_edge_cyc) >= 1500 &&
                                 (last_valid_cyc_n - last_edge_cyc) <= 1540), 32'd1);
        chk("t1_data", 32'(data_n), 32'h55);
        chk("t1_no_ferr", 32'(n_ferr_n - prev_f), 32'd0);
        repeat (50) @(negedge clk);

        // Back-to-back frames with no idle after the stop bit.
        send_frame(1'b0, 8'hA5, 1'b1, 1'b0);
        c1 = last_valid_cyc_n;
        send_frame(1'b0, 8'h3C, 1'b1, 1'b0);
        c2 = last_valid_cyc_n;
        chk("t2_spacing_ok", 32'((c2 - c1) >= 1590 && (c2 - c1) <= 1610), 32'd1);
        chk("t2_data", 32'(data_n), 32'h3C);
        repeat (50) @(negedge clk);

        // Short low glitch is rejected at the half-bit check.
        prev = n_valid_n; prev_f = n_ferr_n;
        rx_n = 1'b0;
        repeat (40) @(negedge clk);
        chk("t3_busy_during", 32'(busy_n), 32'd1);
        rx_n = 1'b1;
        k = 0;
        while (busy_n && k < 100) begin @(negedge clk); k++; end
        chk("t3_busy_clear", 32'(busy_n), 32'd0);
        chk("t3_data_held", 32'(data_n), 32'h3C);
        chk("t3_no_strobes", 32'((n_valid_n - prev) + (n_ferr_n - prev_f)), 32'd0);
        repeat (50) @(negedge clk);

        // Low stop bit followed by a held break.
        prev = n_valid_n; prev_f = n_ferr_n;
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0);
        repeat (240) @(negedge clk);
        chk("t4_busy_in_break", 32'(busy_n), 32'd1);
        chk("t4_one_ferr", 32'(n_ferr_n - prev_f), 32'd1);
        chk("t4_no_valid", 32'(n_valid_n - prev), 32'd0);
        chk("t4_data_held", 32'(data_n), 32'h3C);
        rx_n = 1'b1;
        k = 0;
        while (busy_n && k < 10) begin @(negedge clk); k++; end
        chk("t4_busy_release", 32'(busy_n), 32'd0);
        repeat (50) @(negedge clk);

        // Even parity, 0x07 sent with parity bit 0.
        prev = n_valid_p;
        send_frame(1'b1, 8'h07, 1'b1, 1'b0);
        chk("t5_valid_count", 32'(n_valid_p - prev), 32'd1);
        chk("t5_perr", 32'(last_perr_p), 32'd1);
        chk("t5_data", 32'(data_p), 32'h07);
        repeat (50) @(negedge clk);

        // Reset during data bit 4 of 0x81, then a clean 0x81.
        prev = n_valid_n; prev_f = n_ferr_n;
        rx_n = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d = 8'h81;
            rx_n = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_n = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        chk("t6_busy_before", 32'(busy_n), 32'd1);
        rst = 1'b1; rx_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy_after_rst", 32'(busy_n), 32'd0);
        chk("t6_data_cleared", 32'(data_n), 32'd0);
        repeat (200) @(negedge clk);
        chk("t6_no_strobes", 32'((n_valid_n - prev) + (n_ferr_n - prev_f)), 32'd0);
        send_frame(1'b0, 8'h81, 1'b1, 1'b0);
        chk("t6_data", 32'(data_n), 32'h81);
        repeat (50) @(negedge clk);

        // Random 8N1 frames with random gaps and occasional breaks.
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(1'b0, d, stop, 1'b0);
            if (!stop) begin
                repeat ($urandom_range(0, 200)) @(negedge clk);
                rx_n = 1'b1;
                gap = 20 + int'($urandom_range(0, 100));
            end else begin
                gap = int'($urandom_range(0, 300));
            end
            repeat (gap) @(negedge clk);
        end

        // Random 8E1 frames with random parity bits.
        for (int i = 0; i < 10; i++) begin
            d  = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            send_frame(1'b1, d, 1'b1, pb);
            repeat ($urandom_range(0, 200)) @(negedge clk);
        end

        k = 0;
        while ((exp_n.size() > 0 || exp_p.size() > 0) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_n", 32'(exp_n.size()), 32'd0);
        chk("drain_p", 32'(exp_p.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
